// File: rtl/imem_responder_if.sv
// Fetch request/response bus between the fetch stage (master) and the
// instruction memory responder (slave), plus the loader write port.
// IMEM_PARITY_EN adds the par_inject and rsp_par_err signals.
interface imem_responder_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   flush;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [INSTR_WIDTH-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0]  rsp_addr;
  logic                   rsp_err;
  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [INSTR_WIDTH-1:0] wr_data;
`ifdef IMEM_PARITY_EN
  logic                   par_inject;
  logic                   rsp_par_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data, par_inject,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, rsp_par_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data, par_inject,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, rsp_par_err
  );
`else
  modport master (
    output req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
`endif
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: accepts word fetches, returns them through a
// fixed-latency stallable pipeline, discards in-flight work on flush, and
// hosts the loader write port. Defining IMEM_PARITY_EN adds per-word even
// parity with an injection hook and a parity-error response flag.
module imem_responder #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     IM_SIZE     = 2048,
  parameter int                     LATENCY     = 2,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(32'h00000013)
) (
  input logic               clk,
  input logic               reset,
  imem_responder_if.slave   bus
);

  localparam int WORDS   = IM_SIZE / 4;
  localparam int WORD_AW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] IM_LIMIT = (ADDR_WIDTH + 1)'(IM_SIZE);

  logic [INSTR_WIDTH-1:0] mem [WORDS];

  logic                   stall;
  logic                   accept;
  logic [WORD_AW-1:0]     rdIdx;
  logic [WORD_AW-1:0]     wrIdx;
  logic                   rdInRange;
  logic                   wrInRange;
  logic                   rdMisaligned;
  logic [INSTR_WIDTH-1:0] rdWord;

  logic [INSTR_WIDTH-1:0] instr_d;
  logic                   err_d;
  logic                   parErr_d;

  logic                   stageValid_q  [LATENCY];
  logic [INSTR_WIDTH-1:0] stageInstr_q  [LATENCY];
  logic [ADDR_WIDTH-1:0]  stageAddr_q   [LATENCY];
  logic                   stageErr_q    [LATENCY];
  logic                   stageParErr_q [LATENCY];

  // A held output blocks the whole pipe; a flush always makes room for the redirect target.
  assign stall         = stageValid_q[LATENCY-1] & ~bus.rsp_ready;
  assign bus.req_ready = ~stall | bus.flush;
  assign accept        = bus.req_valid & bus.req_ready;

  assign rdIdx        = bus.req_addr[WORD_AW+1:2];
  assign wrIdx        = bus.wr_addr[WORD_AW+1:2];
  assign rdInRange    = {1'b0, bus.req_addr} < IM_LIMIT;
  assign wrInRange    = {1'b0, bus.wr_addr} < IM_LIMIT;
  assign rdMisaligned = |bus.req_addr[1:0];
  assign rdWord       = mem[rdIdx];

`ifdef IMEM_PARITY_EN
  logic memPar [WORDS];
  logic rdParBad;

  assign rdParBad = (^rdWord) ^ memPar[rdIdx];

  // Stored parity bit keeps data plus parity even; par_inject corrupts it on purpose.
  always_ff @(posedge clk) begin
    if (bus.wr_en && wrInRange) begin
      memPar[wrIdx] <= (^bus.wr_data) ^ bus.par_inject;
    end
  end
`endif

  // Loader writes land at the edge; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (bus.wr_en && wrInRange) begin
      mem[wrIdx] <= bus.wr_data;
    end
  end

  // Build the stage-one response: address/range errors first, then parity, else the memory word.
  always_comb begin
    instr_d  = rdWord;
    err_d    = 1'b0;
    parErr_d = 1'b0;
    if (rdMisaligned || !rdInRange) begin
      instr_d = NOP_INSTR;
      err_d   = 1'b1;
`ifdef IMEM_PARITY_EN
    end else if (rdParBad) begin
      instr_d  = NOP_INSTR;
      err_d    = 1'b1;
      parErr_d = 1'b1;
`endif
    end
  end

  // Response pipeline: flush clears every valid and loads the redirect; otherwise shift unless stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stageValid_q[i]  <= 1'b0;
        stageInstr_q[i]  <= '0;
        stageAddr_q[i]   <= '0;
        stageErr_q[i]    <= 1'b0;
        stageParErr_q[i] <= 1'b0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        stageValid_q[i] <= 1'b0;
      end
      stageValid_q[0]  <= accept;
      stageInstr_q[0]  <= instr_d;
      stageAddr_q[0]   <= bus.req_addr;
      stageErr_q[0]    <= err_d;
      stageParErr_q[0] <= parErr_d;
    end else if (!stall) begin
      stageValid_q[0]  <= accept;
      stageInstr_q[0]  <= instr_d;
      stageAddr_q[0]   <= bus.req_addr;
      stageErr_q[0]    <= err_d;
      stageParErr_q[0] <= parErr_d;
      for (int i = 1; i < LATENCY; i++) begin
        stageValid_q[i]  <= stageValid_q[i-1];
        stageInstr_q[i]  <= stageInstr_q[i-1];
        stageAddr_q[i]   <= stageAddr_q[i-1];
        stageErr_q[i]    <= stageErr_q[i-1];
        stageParErr_q[i] <= stageParErr_q[i-1];
      end
    end
  end

  assign bus.rsp_valid = stageValid_q[LATENCY-1];
  assign bus.rsp_instr = stageInstr_q[LATENCY-1];
  assign bus.rsp_addr  = stageAddr_q[LATENCY-1];
  assign bus.rsp_err   = stageErr_q[LATENCY-1];
`ifdef IMEM_PARITY_EN
  assign bus.rsp_par_err = stageParErr_q[LATENCY-1];
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a reference-model scoreboard:
// expected responses are queued at acceptance and compared at delivery.
module tb_imem_responder;

  localparam int          AW   = 32;
  localparam int          IW   = 32;
  localparam int          IMS  = 2048;
  localparam int          LAT  = 2;
  localparam logic [31:0] NOP  = 32'h00000013;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    logic        parErr;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  rsp_t expQ[$];
  logic [31:0] modelMem [IMS/4];
  bit          modelParBad [IMS/4];

  imem_responder_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

  imem_responder #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .IM_SIZE(IMS), .LATENCY(LAT), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then return #1 after the following rising edge.
  task automatic applyStimulus(input logic rv, input logic [31:0] ra, input logic fl,
                               input logic we, input logic [31:0] wa, input logic [31:0] wd);
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.flush     = fl;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Hold a request until it is accepted, with a bounded wait.
  task automatic sendHeldRequest(input logic [31:0] ra);
    logic acc;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = ra;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = bus.req_ready;
      @(posedge clk);
      #1;
    end
    checkOutput("req_accept_timeout", 32'(acc), 32'h1);
    bus.req_valid = 1'b0;
  endtask

  function automatic rsp_t modelResponse(input logic [31:0] a);
    rsp_t r;
    r.addr   = a;
    r.err    = (a[1:0] != 2'b00) || (a >= 32'(IMS));
    r.parErr = 1'b0;
    r.instr  = r.err ? NOP : modelMem[a[10:2]];
`ifdef IMEM_PARITY_EN
    if (!r.err && modelParBad[a[10:2]]) begin
      r.err    = 1'b1;
      r.parErr = 1'b1;
      r.instr  = NOP;
    end
`endif
    return r;
  endfunction

  // Scoreboard: compare deliveries, then apply flush, queue accepts, then update the model memory.
  always @(negedge clk) begin : scoreboard
    rsp_t e;
    if (reset) begin
      expQ.delete();
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_addr", bus.rsp_addr, e.addr);
          checkOutput("rsp_instr", bus.rsp_instr, e.instr);
          checkOutput("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`ifdef IMEM_PARITY_EN
          checkOutput("rsp_par_err", 32'(bus.rsp_par_err), 32'(e.parErr));
`endif
        end
      end
      if (bus.flush) expQ.delete();
      if (bus.req_valid && bus.req_ready) expQ.push_back(modelResponse(bus.req_addr));
      if (bus.wr_en && (bus.wr_addr < 32'(IMS))) begin
        modelMem[bus.wr_addr[10:2]] = bus.wr_data;
`ifdef IMEM_PARITY_EN
        modelParBad[bus.wr_addr[10:2]] = bus.par_inject;
`endif
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
`ifdef IMEM_PARITY_EN
    bus.par_inject = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("reset_rsp_instr", bus.rsp_instr, 32'h0);
    checkOutput("reset_rsp_addr", bus.rsp_addr, 32'h0);
    checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("req_ready_after_reset", 32'(bus.req_ready), 32'h1);

    // Load program words.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'h00500093);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 32'h00108113);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h08, 32'h00000013);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h00A00193);

    // Back-to-back fetches and latency.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lat_not_yet_valid", 32'(bus.rsp_valid), 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lat_first_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("lat_first_instr", bus.rsp_instr, 32'h00500093);
    idleCycles(1);
    checkOutput("b2b_second_instr", bus.rsp_instr, 32'h00108113);
    checkOutput("b2b_second_valid", 32'(bus.rsp_valid), 32'h1);
    idleCycles(1);
    checkOutput("b2b_drained", 32'(bus.rsp_valid), 32'h0);

    // Misaligned and out-of-range fetches.
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, 32'h0);
    idleCycles(1);
    checkOutput("range_err", 32'(bus.rsp_err), 32'h1);
    checkOutput("range_instr", bus.rsp_instr, NOP);
    checkOutput("range_addr", bus.rsp_addr, 32'h800);
    idleCycles(2);

    // Backpressure: three requests streaming into a stalled output.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    #1;
    checkOutput("stall_req_ready_low", 32'(bus.req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_req_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("stall_hold_addr", bus.rsp_addr, 32'h0);
      checkOutput("stall_hold_instr", bus.rsp_instr, 32'h00500093);
    end
    bus.rsp_ready = 1'b1;
    sendHeldRequest(32'h8);
    idleCycles(4);

    // Flush with two responses in flight.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h0);
    checkOutput("flush_cleared_output", 32'(bus.rsp_valid), 32'h0);
    bus.rsp_ready = 1'b1;
    idleCycles(1);
    checkOutput("flush_target_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("flush_target_addr", bus.rsp_addr, 32'h40);
    checkOutput("flush_target_instr", bus.rsp_instr, 32'h00A00193);
    idleCycles(2);

    // Same-edge write and read of one word returns the old data.
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("wr_rd_old_data", bus.rsp_instr, 32'h00000013);
    idleCycles(1);
    checkOutput("wr_rd_new_data", bus.rsp_instr, 32'hDEADBEEF);
    idleCycles(2);

    // Asynchronous reset while a response is stalled.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    idleCycles(1);
    checkOutput("pre_reset_stalled_valid", 32'(bus.rsp_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("async_reset_instr", bus.rsp_instr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    checkOutput("req_ready_post_reset", 32'(bus.req_ready), 32'h1);
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idleCycles(1);
    checkOutput("post_reset_instr", bus.rsp_instr, 32'h00500093);
    idleCycles(2);

`ifdef IMEM_PARITY_EN
    // Injected parity fault must surface as a parity-sourced error.
    bus.par_inject = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h10, 32'h11111111);
    bus.par_inject = 1'b0;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    idleCycles(1);
    checkOutput("parity_err", 32'(bus.rsp_err), 32'h1);
    checkOutput("parity_par_err", 32'(bus.rsp_par_err), 32'h1);
    checkOutput("parity_instr", bus.rsp_instr, NOP);
    idleCycles(2);
`endif

    idleCycles(3);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch request/response interface.
- Accepts word fetch requests (valid/ready) and returns instructions through a fixed-latency, stallable response pipeline (valid/ready).
- Sits between the fetch stage and instruction storage. Also hosts the loader write port used by testbenches and boot code.
- Supports flush on redirect: in-flight responses from the wrong path are discarded.

Parameters:
- ADDR_WIDTH, 32, byte address width
- INSTR_WIDTH, 32, instruction word width
- IM_SIZE, 2048, memory size in bytes; must be a multiple of 4 (IM_SIZE/4 words)
- LATENCY, 2, response pipeline depth in stages; must be >= 1
- NOP_INSTR, 32'h00000013, word returned on error (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  fetch request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  ADDR_WIDTH  byte address of requested instruction
- flush  in  1  discard all in-flight and held responses
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_instr  out  INSTR_WIDTH  instruction word
- rsp_addr  out  ADDR_WIDTH  echoed request address
- rsp_err  out  1  misaligned or out-of-range request
- wr_en  in  1  loader word write
- wr_addr  in  ADDR_WIDTH  loader byte address; bits [1:0] ignored
- wr_data  in  INSTR_WIDTH  loader data

Behaviour:
- Reset (async): all stage valids clear; rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0. Memory contents are not cleared.
- Stall condition: stall = rsp_valid & ~rsp_ready.
- req_ready = ~stall | flush. This is combinational and does not depend on req_valid.
- The pipeline is LATENCY registered stages; stage LATENCY drives the rsp_* outputs.
- When not stalled, all stages shift by one per cycle.
- When stalled, all stages hold. There is no bubble collapsing.
- Accept: req_valid & req_ready at edge N.
  - Memory is read and errors are evaluated at that edge.
  - rsp_valid is high after edge N+LATENCY-1, provided there is no stall or flush in between.
  - LATENCY=1 gives the response in the cycle after acceptance.
- Back-to-back throughput: one response per cycle while rsp_ready=1.
- Error checks, evaluated at accept:
  - req_addr[1:0] != 0 → rsp_err=1, rsp_instr=NOP_INSTR.
  - req_addr >= IM_SIZE → rsp_err=1, rsp_instr=NOP_INSTR.
  - Otherwise rsp_err=0 and rsp_instr = mem[req_addr >> 2].
- rsp_addr always echoes req_addr unchanged, including on error.
- Flush at edge:
  - All stage valids clear, including a held output.
  - A request presented in the same cycle is accepted into stage 1; this is the redirect target.
  - For LATENCY=1, that request becomes the output directly.
- Write: wr_en at edge writes mem[wr_addr>>2] when in range; out-of-range writes are ignored.
  - A write and a read of the same word at the same edge: the read returns the OLD data.
- Reset mid-operation discards everything in flight. req_ready is 1 the cycle after reset deasserts.
- Output data must stay stable while stalled (rsp_valid & ~rsp_ready).

Optional Feature:
- Macro: IMEM_PARITY_EN.
- With the macro defined:
  - Each word stores an even-parity bit computed on write.
  - The read checks parity; a mismatch sets rsp_err=1 and returns NOP_INSTR.
  - Input port par_inject (1 bit) flips the stored parity bit on the write in which it is high.
  - Output rsp_par_err (1 bit) marks parity-sourced errors.
- Without the macro: no parity storage, no par_inject or rsp_par_err ports, and rsp_err is alignment/range only.

Test Plan:
- Load words 0x00500093 @0x0 and 0x00108113 @0x4; request 0x0 then 0x4 back-to-back with LATENCY=2 and rsp_ready=1 → rsp_valid high 2 cycles after first accept; instrs 0x00500093 then 0x00108113 in consecutive cycles; rsp_err=0.
- Request 0x2, then 0x800 (IM_SIZE=2048) → both responses rsp_err=1, rsp_instr=0x00000013, rsp_addr 0x2 and 0x800.
- Hold rsp_ready=0 with 3 requests streaming → req_ready drops once the output is valid; outputs stable; releasing rsp_ready delivers all 3 in order with no loss or duplication.
- Two requests in flight, assert flush with req_addr=0x40 → the earlier two never appear; the response for 0x40 appears LATENCY-1 cycles after the flush edge.
- wr_en to 0x8 with data 0xDEADBEEF at the same edge a read of 0x8 is accepted (old value 0x00000013) → response 0x00000013; the next read of 0x8 returns 0xDEADBEEF.
- Assert reset while a response is stalled → rsp_valid=0 immediately (async); after release, a new request at 0x0 returns correct data. With IMEM_PARITY_EN: a write with par_inject=1 followed by a read → rsp_err=1 and rsp_par_err=1.
